// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the 32x64 register file: mem wins by default, the ALU wins after MAX_WAIT blocked cycles.
// Registered write port (one cycle after a transfer); ready is combinational; busy scoreboard drives issue stall.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_WAIT   = 4,
  parameter int ZERO_REG   = 31
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [4:0]            alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [4:0]            mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_ready,
  output logic                  wr_en,
  output logic [4:0]            wr_sel,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  claim_valid,
  input  logic [4:0]            claim_rd,
  input  logic [4:0]            chk_rs_a,
  input  logic [4:0]            chk_rs_b,
  input  logic [4:0]            chk_rd,
  output logic                  stall,
  output logic [31:0]           busy
);

  localparam logic [2:0] WAIT_MAX = 3'(MAX_WAIT);
  localparam logic [4:0] ZERO     = 5'(ZERO_REG);

  logic [2:0]            wait_cnt;
  logic                  alu_force;
  logic                  mem_win;
  logic                  alu_win;
  logic                  xfer;
  logic [4:0]            xfer_rd;
  logic [DATA_WIDTH-1:0] xfer_data;
  logic [31:0]           busy_next;

  // Grant depends only on the valids and the wait counter, never on the other ready.
  always_comb begin
    alu_force = alu_valid && (wait_cnt == WAIT_MAX);
    mem_win   = mem_valid && !alu_force;
    alu_win   = alu_valid && !mem_win;
    alu_ready = alu_win && !reset;
    mem_ready = mem_win && !reset;
    xfer      = alu_ready || mem_ready;
    xfer_rd   = mem_ready ? mem_rd   : alu_rd;
    xfer_data = mem_ready ? mem_data : alu_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= 3'd0;
    end else if (alu_ready) begin
      wait_cnt <= 3'd0;
    end else if (alu_valid && (wait_cnt != WAIT_MAX)) begin
      wait_cnt <= wait_cnt + 3'd1;
    end
  end

  // Writes to the zero register are accepted but suppressed; sel/data hold unless a real write occurs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_sel  <= 5'd0;
      wr_data <= '0;
    end else begin
      wr_en <= xfer && (xfer_rd != ZERO);
      if (xfer && (xfer_rd != ZERO)) begin
        wr_sel  <= xfer_rd;
        wr_data <= xfer_data;
      end
    end
  end

  // Clear from the write performed this edge first, then a claim to the same register overrides it.
  always_comb begin
    busy_next = busy;
    if (wr_en) busy_next[wr_sel] = 1'b0;
    if (claim_valid && (claim_rd != ZERO)) busy_next[claim_rd] = 1'b1;
    busy_next[ZERO] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy <= 32'd0;
    end else begin
      busy <= busy_next;
    end
  end

  assign stall = busy[chk_rs_a] | busy[chk_rs_b] | busy[chk_rd];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a randomized run against a reference model.
module tb_regfile_wb_arbiter;

  localparam int DW = 64;
  localparam int MAXW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          alu_valid = 1'b0;
  logic [4:0]    alu_rd = 5'd0;
  logic [DW-1:0] alu_data = '0;
  logic          alu_ready;
  logic          mem_valid = 1'b0;
  logic [4:0]    mem_rd = 5'd0;
  logic [DW-1:0] mem_data = '0;
  logic          mem_ready;
  logic          wr_en;
  logic [4:0]    wr_sel;
  logic [DW-1:0] wr_data;
  logic          claim_valid = 1'b0;
  logic [4:0]    claim_rd = 5'd0;
  logic [4:0]    chk_rs_a = 5'd31;
  logic [4:0]    chk_rs_b = 5'd31;
  logic [4:0]    chk_rd = 5'd31;
  logic          stall;
  logic [31:0]   busy;

  int tests_run = 0;
  int tests_failed = 0;

  regfile_wb_arbiter #(.DATA_WIDTH(DW), .MAX_WAIT(MAXW), .ZERO_REG(31)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .claim_valid(claim_valid), .claim_rd(claim_rd),
    .chk_rs_a(chk_rs_a), .chk_rs_b(chk_rs_b), .chk_rd(chk_rd),
    .stall(stall), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    alu_valid = 0; mem_valid = 0; claim_valid = 0;
    alu_rd = 0; mem_rd = 0; claim_rd = 0;
    alu_data = '0; mem_data = '0;
    chk_rs_a = 31; chk_rs_b = 31; chk_rd = 31;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clock);
    reset = 1;
    #1;
    reset = 0;
    tick();
  endtask

  task automatic test_reset();
    alu_valid = 1; mem_valid = 1;
    #1;
    tests_run++;
    if ({alu_ready, mem_ready} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_ready: got %b expected 00", {alu_ready, mem_ready});
    end
    tests_run++;
    if ({wr_en, wr_sel, wr_data, busy, stall} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: wr_en=%b sel=%0d data=%0h busy=%0h stall=%b expected all 0",
               wr_en, wr_sel, wr_data, busy, stall);
    end
    clear_inputs();
    reset = 0;
    tick();
    tick();
    tests_run++;
    if ({alu_ready, mem_ready, wr_en, stall} !== 4'b0000 || busy !== 32'd0) begin
      tests_failed++;
      $display("FAIL idle: ready=%b%b wr_en=%b stall=%b busy=%0h expected zeros",
               alu_ready, mem_ready, wr_en, stall, busy);
    end
  endtask

  task automatic test_alu_write();
    do_reset();
    alu_valid = 1; alu_rd = 5; alu_data = 64'hDEAD_BEEF;
    #1;
    tests_run++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
      tests_failed++; $display("FAIL alu_grant: alu_ready=%b mem_ready=%b expected 1 0", alu_ready, mem_ready);
    end
    tick();
    alu_valid = 0;
    tests_run++;
    if (wr_en !== 1'b1 || wr_sel !== 5'd5 || wr_data !== 64'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL alu_write: wr_en=%b sel=%0d data=%0h expected 1 5 deadbeef", wr_en, wr_sel, wr_data);
    end
    tick();
    tests_run++;
    if (wr_en !== 1'b0 || wr_sel !== 5'd5) begin
      tests_failed++; $display("FAIL alu_write_end: wr_en=%b sel=%0d expected 0 5", wr_en, wr_sel);
    end
  endtask

  task automatic test_arbitration();
    int mem_idx;
    logic [4:0] exp_sel;
    do_reset();
    mem_idx = 1;
    alu_valid = 1; alu_rd = 9; alu_data = 64'h99;
    mem_valid = 1;
    for (int c = 0; c < 9; c++) begin
      mem_rd = 5'(mem_idx); mem_data = 64'(mem_idx * 16);
      #1;
      tests_run++;
      if (alu_ready !== (c == 4) || mem_ready !== (c != 4)) begin
        tests_failed++;
        $display("FAIL arb_cycle%0d: alu_ready=%b mem_ready=%b expected %b %b",
                 c, alu_ready, mem_ready, c == 4, c != 4);
      end
      exp_sel = (c == 4) ? 5'd9 : 5'(mem_idx);
      tick();
      if (c == 4) alu_valid = 0;
      else mem_idx++;
      tests_run++;
      if (wr_en !== 1'b1 || wr_sel !== exp_sel) begin
        tests_failed++;
        $display("FAIL arb_write%0d: wr_en=%b sel=%0d expected 1 %0d", c, wr_en, wr_sel, exp_sel);
      end
    end
    clear_inputs();
  endtask

  task automatic test_scoreboard();
    do_reset();
    claim_valid = 1; claim_rd = 7;
    tick();
    claim_valid = 0; chk_rs_a = 7;
    #1;
    tests_run++;
    if (stall !== 1'b1 || busy !== 32'h80) begin
      tests_failed++; $display("FAIL claim7: stall=%b busy=%0h expected 1 80", stall, busy);
    end
    alu_valid = 1; alu_rd = 7; alu_data = 64'h77;
    tick();
    alu_valid = 0;
    tests_run++;
    if (wr_en !== 1'b1 || busy[7] !== 1'b1 || stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL write7_pending: wr_en=%b busy7=%b stall=%b expected 1 1 1", wr_en, busy[7], stall);
    end
    tick();
    tests_run++;
    if (busy !== 32'd0 || stall !== 1'b0) begin
      tests_failed++; $display("FAIL write7_cleared: busy=%0h stall=%b expected 0 0", busy, stall);
    end
  endtask

  task automatic test_claim_clear_same();
    do_reset();
    claim_valid = 1; claim_rd = 3;
    tick();
    claim_valid = 0;
    mem_valid = 1; mem_rd = 3; mem_data = 64'h33;
    tick();
    mem_valid = 0;
    claim_valid = 1; claim_rd = 3;
    tick();
    claim_valid = 0;
    tests_run++;
    if (busy !== 32'h8) begin
      tests_failed++; $display("FAIL claim_wins: busy=%0h expected 8", busy);
    end
    tick();
    tests_run++;
    if (busy !== 32'h8) begin
      tests_failed++; $display("FAIL claim_holds: busy=%0h expected 8", busy);
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    mem_valid = 1; mem_rd = 31; mem_data = 64'h1234;
    #1;
    tests_run++;
    if (mem_ready !== 1'b1) begin
      tests_failed++; $display("FAIL zero_ready: mem_ready=%b expected 1", mem_ready);
    end
    tick();
    mem_valid = 0;
    claim_valid = 1; claim_rd = 31;
    tests_run++;
    if (wr_en !== 1'b0) begin
      tests_failed++; $display("FAIL zero_write: wr_en=%b expected 0", wr_en);
    end
    tick();
    claim_valid = 0;
    tests_run++;
    if (busy !== 32'd0) begin
      tests_failed++; $display("FAIL zero_claim: busy=%0h expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int r = 4; r < 8; r++) begin
      claim_valid = 1; claim_rd = 5'(r);
      tick();
    end
    claim_valid = 0;
    alu_valid = 1; alu_rd = 1; alu_data = 64'h11;
    tick();
    chk_rs_a = 4;
    #1;
    tests_run++;
    if (wr_en !== 1'b1 || busy !== 32'h0000_00F0) begin
      tests_failed++; $display("FAIL mid_setup: wr_en=%b busy=%0h expected 1 f0", wr_en, busy);
    end
    #1;
    reset = 1;
    #1;
    tests_run++;
    if ({wr_en, wr_sel, wr_data, busy, stall, alu_ready, mem_ready} !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset: wr_en=%b sel=%0d data=%0h busy=%0h stall=%b ready=%b%b expected all 0",
               wr_en, wr_sel, wr_data, busy, stall, alu_ready, mem_ready);
    end
    #1;
    reset = 0;
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    int            blocked;
    logic [31:0]   m_busy;
    logic          m_en;
    logic [4:0]    m_sel;
    logic [DW-1:0] m_data;
    logic          alu_hold, mem_hold, e_alu, e_mem, e_stall;
    logic [4:0]    g_rd;
    logic [DW-1:0] g_data;
    do_reset();
    blocked = 0; m_busy = 0; m_en = 0; m_sel = 0; m_data = '0;
    alu_hold = 0; mem_hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (!alu_hold) begin
        alu_valid = 1'($urandom_range(0, 1));
        alu_rd = 5'($urandom_range(0, 31));
        alu_data = {$urandom, $urandom};
      end
      if (!mem_hold) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_rd = 5'($urandom_range(0, 31));
        mem_data = {$urandom, $urandom};
      end
      claim_valid = ($urandom_range(0, 3) == 0);
      claim_rd = 5'($urandom_range(0, 31));
      chk_rs_a = 5'($urandom_range(0, 31));
      chk_rs_b = 5'($urandom_range(0, 31));
      chk_rd = 5'($urandom_range(0, 31));
      #1;
      if (alu_valid && mem_valid) begin
        e_alu = (blocked >= MAXW);
        e_mem = !e_alu;
      end else begin
        e_alu = alu_valid;
        e_mem = mem_valid;
      end
      e_stall = m_busy[chk_rs_a] || m_busy[chk_rs_b] || m_busy[chk_rd];
      tests_run++;
      if (alu_ready !== e_alu || mem_ready !== e_mem || stall !== e_stall) begin
        tests_failed++;
        $display("FAIL rand_grant%0d: ready=%b%b stall=%b expected %b%b %b",
                 i, alu_ready, mem_ready, stall, e_alu, e_mem, e_stall);
      end
      if (m_en) m_busy[m_sel] = 0;
      if (claim_valid && claim_rd != 31) m_busy[claim_rd] = 1;
      if (e_alu) blocked = 0;
      else if (alu_valid && blocked < MAXW) blocked++;
      g_rd = e_mem ? mem_rd : alu_rd;
      g_data = e_mem ? mem_data : alu_data;
      m_en = (e_alu || e_mem) && g_rd != 31;
      if (m_en) begin
        m_sel = g_rd;
        m_data = g_data;
      end
      alu_hold = alu_valid && !e_alu;
      mem_hold = mem_valid && !e_mem;
      tick();
      tests_run++;
      if (wr_en !== m_en || busy !== m_busy || (m_en && (wr_sel !== m_sel || wr_data !== m_data))) begin
        tests_failed++;
        $display("FAIL rand_write%0d: wr_en=%b sel=%0d data=%0h busy=%0h expected %b %0d %0h %0h",
                 i, wr_en, wr_sel, wr_data, busy, m_en, m_sel, m_data, m_busy);
      end
    end
    clear_inputs();
  endtask

  initial begin
    #2;
    test_reset();
    test_alu_write();
    test_arbitration();
    test_scoreboard();
    test_claim_clear_same();
    test_zero_reg();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-port controller for the 32x64 register file: one write port, two read ports, 5-bit selects.
- Arbitrates two writeback requesters (ALU and memory-load) onto the single write port through a valid/ready handshake.
- Maintains a pending-write scoreboard so the issue stage can stall on RAW/WAW hazards.
- Sits between the execute/memory stages and the register file write inputs (data, decoder select, write enable).

Parameters:
- DATA_WIDTH, 64, writeback data width.
- MAX_WAIT, 4, consecutive ALU-blocked cycles before the ALU is forced to win one grant (1..7).
- ZERO_REG, 31, hardwired-zero register index; never written, never busy.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- alu_valid  input  1  ALU writeback request.
- alu_rd  input  5  ALU destination register.
- alu_data  input  DATA_WIDTH  ALU result.
- alu_ready  output  1  ALU request granted this cycle.
- mem_valid  input  1  load writeback request.
- mem_rd  input  5  load destination register.
- mem_data  input  DATA_WIDTH  load data.
- mem_ready  output  1  load request granted this cycle.
- wr_en  output  1  register file write enable (registered).
- wr_sel  output  5  register file decoder select (registered).
- wr_data  output  DATA_WIDTH  register file data in (registered).
- claim_valid  input  1  issue stage reserves a destination.
- claim_rd  input  5  register being reserved.
- chk_rs_a  input  5  issuing instruction source A.
- chk_rs_b  input  5  issuing instruction source B.
- chk_rd  input  5  issuing instruction destination.
- stall  output  1  hazard: issuing instruction must hold.
- busy  output  32  scoreboard, bit r = write pending to register r.

Behaviour:
- Reset (asynchronous, any time):
  - wr_en=0, wr_sel=0, wr_data=0, busy=0, wait counter=0.
  - alu_ready=mem_ready=0 while reset is high.
  - A request in flight at reset is dropped; the requester must re-present it after reset.
- Handshake:
  - A transfer occurs when valid&ready at a rising edge.
  - Requesters hold valid/rd/data stable until the transfer.
  - ready is combinational from valid and arbiter state; it never depends on the same cycle's ready of the other port.
  - At most one of alu_ready/mem_ready is high per cycle.
  - When only one requester is valid, it is granted that cycle.
- Arbitration:
  - Default: mem wins when both are valid.
  - Wait counter increments each cycle alu_valid=1 and alu_ready=0, saturating at MAX_WAIT.
  - When the counter equals MAX_WAIT and alu_valid=1, the ALU wins.
  - The counter clears on any ALU transfer.
- Write port, latency 1:
  - A transfer at edge N drives wr_en=1, wr_sel=rd, wr_data=data during cycle N+1; the register file captures at edge N+1.
  - With no transfer, wr_en=0 next cycle; wr_sel/wr_data hold their previous values.
  - Transfer with rd=ZERO_REG: accepted (ready=1) but wr_en stays 0.
  - Back-to-back transfers give consecutive wr_en cycles, one write per cycle.
- Scoreboard:
  - claim_valid at an edge sets busy[claim_rd] unless claim_rd=ZERO_REG.
  - A write performed (wr_en=1 at the register file edge, i.e. the cycle after the transfer) clears busy[wr_sel].
  - Claim and clear to the same register in the same edge: busy stays 1 (claim wins).
  - A write to a non-busy register is legal and leaves busy unchanged.
  - busy[ZERO_REG] is constant 0.
- Stall (combinational):
  - stall = busy[chk_rs_a] | busy[chk_rs_b] | busy[chk_rd].
  - The WAW check guarantees at most one outstanding writer per register.
  - There is no forwarding; the register becomes readable the cycle after busy clears.

Test Plan:
- Reset, then idle -> wr_en=0, busy=0, stall=0, both ready=0 with no valid.
- alu_valid, alu_rd=5, alu_data=0xDEAD_BEEF at edge 1 -> alu_ready=1 in cycle 1; wr_en=1, wr_sel=5, wr_data=0xDEADBEEF in cycle 2; wr_en=0 in cycle 3.
- Both valid continuously, mem_rd=1..8, alu_rd=9, MAX_WAIT=4 -> mem granted 4 cycles, ALU granted 5th cycle, counter clears, mem resumes.
- claim_rd=7, then chk_rs_a=7 -> stall=1; ALU writes rd=7 -> busy[7] clears the cycle after wr_en=1, stall=0 from then on.
- Claim rd=3 on the same edge that wr_en=1/wr_sel=3 clears it -> busy[3]=1 afterwards.
- mem write rd=31 -> mem_ready=1, wr_en stays 0.
- claim_rd=31 -> busy stays 0.
- Assert reset mid-transfer, with busy=0x0000_00F0 and wr_en=1 -> all outputs 0 immediately, without waiting for an edge.
